// File: rtl/packet_parser_if.sv
// Bundles the parser's input byte stream, framed payload output and header/error outputs.
// Both streams use valid/ready: a beat transfers on a rising clock edge where
// tvalid and tready are both high; a source holds tvalid and its data
// unchanged until that edge and never waits on tready before raising tvalid.
interface packet_parser_if;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  opcode_o;
  logic [15:0] len_o;
  logic        hdr_valid_o;
  logic        err_o;

  modport master (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    input  opcode_o, len_o, hdr_valid_o, err_o
  );

  modport slave (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
    output opcode_o, len_o, hdr_valid_o, err_o
  );
endinterface

// File: rtl/packet_parser.sv
// Strips the 4-byte header (opcode, reserved, 16-bit LE length) from a byte stream
// and forwards the payload through a single-stage output register with tlast.
module packet_parser #(
  parameter int unsigned TimeoutCycles = 0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  packet_parser_if.slave   bus,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    ST_OPCODE  = 3'd0,
    ST_RSVD    = 3'd1,
    ST_LEN_LO  = 3'd2,
    ST_LEN_HI  = 3'd3,
    ST_PAYLOAD = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TimeoutCycles);
  localparam bit          TIMEOUT_EN  = (TimeoutCycles != 0);

  state_t      state_q, state_d;
  logic [7:0]  opcode_pend_q, len_lo_q;
  logic [15:0] remaining_q, idle_q;
  logic [7:0]  out_data_q;
  logic        out_valid_q, out_last_q;
  logic [7:0]  opcode_q;
  logic [15:0] len_q;
  logic        hdr_q, err_q;

  logic        s_ready, accept, timeout_hit;
  logic        hdr_fire, len_err, load_byte;
  logic [15:0] hdr_len, idle_inc;

  // The output register frees up in the same cycle it drains, so payload runs at full rate.
  assign s_ready  = !reset_i && ((state_q != ST_PAYLOAD) || !out_valid_q || bus.m_axis_tready);
  assign accept   = bus.s_axis_tvalid && s_ready;
  assign hdr_len  = {bus.s_axis_tdata, len_lo_q};
  assign idle_inc = idle_q + 16'd1;
  assign timeout_hit = TIMEOUT_EN && (state_q != ST_OPCODE) && !bus.s_axis_tvalid
                       && (idle_inc == TIMEOUT_LIM);

  always_comb begin
    state_d   = state_q;
    hdr_fire  = 1'b0;
    len_err   = 1'b0;
    load_byte = 1'b0;
    if (timeout_hit) begin
      state_d = ST_OPCODE;
    end else if (accept) begin
      case (state_q)
        ST_OPCODE: state_d = ST_RSVD;
        ST_RSVD:   state_d = ST_LEN_LO;
        ST_LEN_LO: state_d = ST_LEN_HI;
        ST_LEN_HI: begin
          if (hdr_len < 16'd4) begin
            len_err = 1'b1;
            state_d = ST_OPCODE;
          end else begin
            hdr_fire = 1'b1;
            state_d  = (hdr_len == 16'd4) ? ST_OPCODE : ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          load_byte = 1'b1;
          if (remaining_q == 16'd1) state_d = ST_OPCODE;
        end
        default: state_d = ST_OPCODE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= ST_OPCODE;
      opcode_pend_q <= '0;
      len_lo_q      <= '0;
      remaining_q   <= '0;
      idle_q        <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      opcode_q      <= '0;
      len_q         <= '0;
      hdr_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_fire;
      err_q   <= len_err || timeout_hit;

      if (accept && state_q == ST_OPCODE) opcode_pend_q <= bus.s_axis_tdata;
      if (accept && state_q == ST_LEN_LO) len_lo_q      <= bus.s_axis_tdata;

      if (hdr_fire) begin
        opcode_q    <= opcode_pend_q;
        len_q       <= hdr_len;
        remaining_q <= hdr_len - 16'd4;
      end else if (load_byte) begin
        remaining_q <= remaining_q - 16'd1;
      end

      // Only true input silence counts; beats held off by a full output register do not.
      if (accept || timeout_hit || state_q == ST_OPCODE) idle_q <= '0;
      else if (!bus.s_axis_tvalid)                        idle_q <= idle_inc;

      if (load_byte) begin
        out_data_q  <= bus.s_axis_tdata;
        out_last_q  <= (remaining_q == 16'd1);
        out_valid_q <= 1'b1;
      end else if (bus.m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.s_axis_tready = s_ready;
  assign bus.m_axis_tdata  = out_data_q;
  assign bus.m_axis_tvalid = out_valid_q;
  assign bus.m_axis_tlast  = out_last_q;
  assign bus.opcode_o      = opcode_q;
  assign bus.len_o         = len_q;
  assign bus.hdr_valid_o   = hdr_q;
  assign bus.err_o         = err_q;
  assign state_dbg         = state_q;

endmodule

// File: doc/packet_parser.md
# packet_parser

Byte-stream packet parser between `uart_rx` and the ALU datapath inside `alu_wrap`. It consumes the raw received byte stream and strips the 4-byte header: opcode, reserved byte, then 16-bit little-endian total length. It presents the header fields to the ALU controller and forwards the payload bytes as a framed stream with `tlast`. Packets whose length is malformed are flagged and discarded, and an optional inter-byte timeout recovers from truncated packets.

## Interface
- `TimeoutCycles`, default 0: number of consecutive idle input cycles that aborts a packet in progress; 0 disables the timeout.
- `clk_i`  in  1  single clock for the block.
- `reset_i`  in  1  asynchronous, active-high reset.
- `s_axis_tdata`  in  8  received byte from `uart_rx`.
- `s_axis_tvalid`  in  1  received byte valid.
- `s_axis_tready`  out  1  parser accepts the byte this cycle.
- `opcode_o`  out  8  opcode of the most recent header.
- `len_o`  out  16  total packet length of the most recent header, header bytes included.
- `hdr_valid_o`  out  1  one-cycle pulse: `opcode_o`/`len_o` updated.
- `m_axis_tdata`  out  8  payload byte.
- `m_axis_tvalid`  out  1  payload byte valid.
- `m_axis_tready`  in  1  downstream accepts the payload byte.
- `m_axis_tlast`  out  1  marks the final payload byte of a packet.
- `err_o`  out  1  one-cycle pulse: bad length or timeout abort.

## Operation
- Input beat accepted when `s_axis_tvalid && s_axis_tready`.
- States: `OPCODE` (reset state), `RSVD`, `LEN_LO`, `LEN_HI`, `PAYLOAD`.
- `OPCODE`: accepted byte latched as pending opcode → `RSVD`.
- `RSVD`: accepted byte ignored, any value → `LEN_LO`.
- `LEN_LO`: byte latched as len[7:0] → `LEN_HI`.
- `LEN_HI`: byte forms len[15:8]; full length L = {byte, len_lo}.
  - L < 4: pulse `err_o`, `opcode_o`/`len_o` unchanged, no `hdr_valid_o` → `OPCODE`.
  - L == 4: update `opcode_o`/`len_o`, pulse `hdr_valid_o` → `OPCODE` (no payload).
  - L > 4: update outputs, pulse `hdr_valid_o`, load 16-bit remaining = L − 4 → `PAYLOAD`.
- `PAYLOAD`: each accepted byte is loaded into the output register; remaining decrements.
  - `m_axis_tlast` is set with the byte loaded when remaining == 1.
  - After that byte → `OPCODE`.
  - Maximum L = 0xFFFF gives 65531 payload bytes; no wrap.
- Output register: single stage.
  - `m_axis_tvalid` holds until `m_axis_tready`.
  - `m_axis_tdata`/`m_axis_tlast` are stable while valid and not ready.
- `s_axis_tready`:
  - 1 in header states.
  - In `PAYLOAD`, `!m_axis_tvalid || m_axis_tready`.
  - 0 while `reset_i` is high.
- Timeout (`TimeoutCycles` > 0):
  - 16-bit idle counter, active outside `OPCODE`.
  - Increments each cycle `s_axis_tvalid` is 0; clears on any accepted beat.
  - Cycles stalled by `s_axis_tready` = 0 do not count.
  - Counter reaching `TimeoutCycles` → pulse `err_o`, → `OPCODE`.
  - A payload byte already in the output register is still delivered, but no `tlast` is generated for the aborted packet; downstream uses `err_o` to abort.
- Reset mid-packet: state → `OPCODE`, all counters cleared, output register emptied.

## Timing
- Reset values: `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `hdr_valid_o`, `err_o`, `opcode_o`, `len_o` all 0.
- `hdr_valid_o` pulse and updated `opcode_o`/`len_o` appear the cycle after the `LEN_HI` byte is accepted.
- `err_o` pulse appears the cycle after the `LEN_HI` byte is accepted, or the cycle after the timeout count is reached.
- Payload latency: byte accepted on edge N → `m_axis_tvalid` high after edge N.
- Full throughput: one byte per cycle when `m_axis_tready` is held 1.
- An `OPCODE` byte may be accepted the cycle after the last payload beat is accepted; the output register may still hold that last byte.
- Simultaneous output drain and new input load in one cycle: the new byte replaces the old one, valid stays 1.

## Test plan
- Bytes EC 00 06 00 48 69, `m_axis_tready` = 1 → one `hdr_valid_o` pulse with `opcode_o` = EC, `len_o` = 0006; then 48 (tlast 0), 69 (tlast 1).
- Same packet with `m_axis_tready` toggling 1-0-0-1 → no byte lost or duplicated; data held stable during stalls; `s_axis_tready` low while the register is full and stalled.
- Bytes A1 00 03 00 → `err_o` pulse, no header pulse; the next packet EC 00 04 00 gives `hdr_valid_o` with `len_o` = 0004 and zero payload beats.
- `TimeoutCycles` = 50: EC 00 08 00 11 22 then a 60-cycle input gap → 11, 22 delivered without tlast, `err_o` pulses at idle cycle 50; a following EC 00 05 00 33 parses normally with 33 marked tlast.
- `TimeoutCycles` = 0 with a 2000-cycle gap between payload bytes → no error; the packet completes correctly.
- `reset_i` asserted during `PAYLOAD` → outputs zero immediately; after release, a full packet EC 00 06 00 48 69 parses correctly.
